// File: rtl/cachebusseq.sv
// Cache-line burst sequencer: turns one line fetch/writeback request into an
// AHB-Lite incrementing burst with pipelined address and data phases.
module cachebusseq #(
    parameter int PA_BITS = 32,
    parameter int BEATLEN = 64,
    parameter int LINELEN = 512,
    parameter int LOGBWPL = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Stall,
    input  logic               FlushStage,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATLEN-1:0] CacheReadDataWord,
    output logic               CacheBusAck,
    output logic               SelBusBeat,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               BusCommitted,
    output logic [PA_BITS-1:0] HADDR,
    output logic [1:0]         HTRANS,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [BEATLEN-1:0] HWDATA,
    input  logic               HREADY,
    input  logic [BEATLEN-1:0] HRDATA
);

    localparam int OFFSET   = $clog2(LINELEN / 8);
    localparam int BYTEBITS = OFFSET - LOGBWPL;
    localparam logic [LOGBWPL-1:0] LASTBEAT = '1;
    localparam logic [2:0] BURSTCODE = (LOGBWPL == 2) ? 3'b011 :
                                       (LOGBWPL == 3) ? 3'b101 :
                                       (LOGBWPL == 4) ? 3'b111 : 3'b001;

    typedef enum logic [1:0] {IDLE, FETCH, WRITEBACK, DONE} stateT;

    stateT                      state;
    logic [PA_BITS-OFFSET-1:0]  lineAdr;
    logic [LOGBWPL-1:0]         adrBeat;
    logic [LOGBWPL-1:0]         dataBeat;
    logic                       adrDone;
    logic                       dataPhase;
    logic                       inBurst;
    logic                       adrAccept;
    logic                       beatDone;
    logic                       lastBeat;
    logic                       unusedAdrBits;

    assign unusedAdrBits = ^CacheBusAdr[OFFSET-1:0];

    assign inBurst   = (state == FETCH) || (state == WRITEBACK);
    assign adrAccept = HREADY && (HTRANS != 2'b00);
    assign beatDone  = inBurst && dataPhase && HREADY;
    assign lastBeat  = beatDone && (dataBeat == LASTBEAT);

    // Derived purely from reset-cleared registers, so reset forces IDLE at once.
    always_comb begin
        HTRANS = 2'b00;
        if (inBurst && !adrDone)
            HTRANS = (adrBeat == '0) ? 2'b10 : 2'b11;
    end

    assign HADDR        = {lineAdr, adrBeat, {BYTEBITS{1'b0}}};
    assign HWRITE       = (state == WRITEBACK);
    assign SelBusBeat   = (state == WRITEBACK);
    assign BusCommitted = (state != IDLE);
    assign BeatCount    = dataBeat;
    assign CacheBusAck  = lastBeat;
    assign HWDATA       = CacheReadDataWord;
    assign HSIZE        = 3'($clog2(BEATLEN / 8));
    assign HBURST       = BURSTCODE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            lineAdr     <= '0;
            adrBeat     <= '0;
            dataBeat    <= '0;
            adrDone     <= 1'b0;
            dataPhase   <= 1'b0;
            FetchBuffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((CacheBusRW != 2'b00) && !FlushStage) begin
                        state     <= CacheBusRW[1] ? FETCH : WRITEBACK;
                        lineAdr   <= CacheBusAdr[PA_BITS-1:OFFSET];
                        adrBeat   <= '0;
                        dataBeat  <= '0;
                        adrDone   <= 1'b0;
                        dataPhase <= 1'b0;
                    end
                end
                FETCH, WRITEBACK: begin
                    if (adrAccept) begin
                        adrBeat <= adrBeat + 1'b1;
                        if (adrBeat == LASTBEAT)
                            adrDone <= 1'b1;
                    end
                    // A completing beat keeps the data phase open only if the next address went out with it.
                    if (HREADY)
                        dataPhase <= adrAccept;
                    if (beatDone) begin
                        dataBeat <= dataBeat + 1'b1;
                        if (state == FETCH)
                            FetchBuffer[dataBeat*BEATLEN +: BEATLEN] <= HRDATA;
                    end
                    if (lastBeat)
                        state <= ((state == FETCH) && Stall) ? DONE : IDLE;
                end
                DONE: begin
                    if (!Stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        (state == IDLE) |-> (CacheBusRW != 2'b11));

endmodule

// File: doc/cachebusseq.md
# cachebusseq

Burst sequencer between a cache and the AHB-Lite bus. It turns a cache line request (`CacheBusRW`, `CacheBusAdr`) into a pipelined incrementing burst. On a fetch it assembles incoming beats into `FetchBuffer`; on a writeback it steers the cache's read-word mux through `BeatCount`/`SelBusBeat` and drives the selected word onto `HWDATA`. It returns `CacheBusAck` when the last beat completes and is instantiated once per cache, beside the I$ and D$.

## Interface
- `PA_BITS`, 32, physical address width
- `BEATLEN`, 64, bus data width in bits (power of two, ≥32)
- `LINELEN`, 512, cache line width in bits (multiple of `BEATLEN`)
- `LOGBWPL`, 3, log2(`LINELEN`/`BEATLEN`); beats per line `NB` = 2^`LOGBWPL`
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = reset)
- `Stall`  input  1  pipeline stall; holds completion state after a fetch
- `FlushStage`  input  1  flush of requesting stage; suppresses a not-yet-started request
- `CacheBusRW`  input  2  [1] line fetch, [0] line writeback; both set is illegal
- `CacheBusAdr`  input  PA_BITS  line-aligned address
- `CacheReadDataWord`  input  BEATLEN  cache word selected by `BeatCount` (writeback data)
- `CacheBusAck`  output  1  one-cycle pulse: last beat completed
- `SelBusBeat`  output  1  cache word select comes from `BeatCount`
- `BeatCount`  output  LOGBWPL  current data-phase beat index
- `FetchBuffer`  output  LINELEN  assembled fetched line
- `BusCommitted`  output  1  a burst is in flight; must not be killed
- `HADDR`  output  PA_BITS  AHB address
- `HTRANS`  output  2  00 IDLE, 10 NONSEQ, 11 SEQ
- `HWRITE`  output  1  AHB write
- `HSIZE`  output  3  log2(`BEATLEN`/8)
- `HBURST`  output  3  `NB`=4→011, 8→101, 16→111, else 001
- `HWDATA`  output  BEATLEN  write data
- `HREADY`  input  1  AHB ready
- `HRDATA`  input  BEATLEN  AHB read data

## Operation
- States: IDLE, FETCH, WRITEBACK, DONE.
- IDLE:
  - `CacheBusRW[1]` & ~`FlushStage` → FETCH.
  - `CacheBusRW[0]` & ~`FlushStage` → WRITEBACK.
  - Otherwise stay in IDLE. A request with `FlushStage`=1 is dropped.
- On leaving IDLE, latch the line address `LA`=`CacheBusAdr[PA_BITS-1:OFFSET]` and clear `AdrBeat`, `DataBeat`, `AdrDone`, `DataPhase`. Here OFFSET = log2(`LINELEN`/8).
- Address phase (FETCH/WRITEBACK):
  - `HADDR` = {`LA`, `AdrBeat`, zeros}.
  - `HTRANS` = NONSEQ when `AdrBeat`=0 and no address has been accepted yet; SEQ for later beats; IDLE once `AdrDone`.
  - An address is accepted when `HREADY` & `HTRANS`≠IDLE. Acceptance sets `DataPhase`, increments `AdrBeat`, and sets `AdrDone` when `AdrBeat`=`NB`-1.
- Data phase:
  - A beat completes when `DataPhase` & `HREADY`. It increments `DataBeat` (wrapping to 0 after `NB`-1).
  - On completion, `DataPhase` stays set only if an address was accepted in the same cycle.
  - FETCH: `FetchBuffer[DataBeat*BEATLEN +: BEATLEN]` ← `HRDATA` on each completed beat.
  - WRITEBACK: `HWDATA` = `CacheReadDataWord` combinationally.
- Last beat completes (`DataBeat`=`NB`-1): `CacheBusAck`=1 for that cycle only.
  - From FETCH: go to DONE if `Stall`, else IDLE.
  - From WRITEBACK: always go to IDLE, so a following fetch can start.
- DONE: ignore `CacheBusRW`; go to IDLE when ~`Stall`.
- `FlushStage` is ignored outside IDLE.
- `HWRITE`=1 and `SelBusBeat`=1 in WRITEBACK, else 0. `BeatCount`=`DataBeat`. `BusCommitted`=(state≠IDLE).
- `HSIZE` and `HBURST` are constant.
- `FetchBuffer` holds its value until beats of the next fetch overwrite it.
- Both `CacheBusRW` bits set in IDLE: fetch wins. This is an illegal input; an assertion is required.

## Timing
- Reset (async): state IDLE; counters and flags 0. Every output is 0: `HTRANS`, `HADDR`, `HWRITE`, `CacheBusAck`, `SelBusBeat`, `BeatCount`, `BusCommitted`, `FetchBuffer`. The only exceptions are the constant `HSIZE` and `HBURST`.
- Reset asserted mid-burst: `HTRANS`=IDLE immediately and asynchronously. No ack is issued. `FetchBuffer` clears.
- Request seen in IDLE at cycle 0 → NONSEQ in cycle 1. With zero wait states, addresses occupy cycles 1..`NB` and data cycles 2..`NB`+1. `CacheBusAck` is high in cycle `NB`+1.
- `HREADY`=0 freezes both the address and the data beat; no counter advances.
- The cache must hold `CacheReadDataWord` valid for the current `BeatCount` during the writeback data phase.

## Test plan
- Fetch, `NB`=8, `HREADY`=1, `CacheBusAdr`=0x80001040, `HRDATA`=beat index → HADDR 0x80001040..0x80001078 in cycles 1–8; NONSEQ then 7×SEQ; ack in cycle 9; `FetchBuffer` beat i = i.
- Writeback, `CacheReadDataWord`=0xA0+`BeatCount` → `HWRITE`=1, `SelBusBeat`=1, `HWDATA` 0xA0..0xA7 in cycles 2–9, ack in cycle 9, IDLE in cycle 10.
- Fetch with `HREADY`=0 on cycles 3 and 4 → addresses and data stall two cycles; ack in cycle 11; buffer contents unchanged vs. the no-wait run.
- Fetch ending with `Stall`=1 for 3 cycles while `CacheBusRW` stays 10 → state DONE, no second NONSEQ; IDLE the cycle after `Stall` drops.
- Request with `FlushStage`=1 in IDLE → `HTRANS` stays IDLE, `BusCommitted`=0. `FlushStage`=1 at beat 4 → burst completes normally.
- `reset`=0 at beat 5 of a fetch → `HTRANS`=IDLE and all outputs 0 at once; a new fetch after release starts with NONSEQ at `AdrBeat`=0.
